key_event_decoder: RTL and testbench



---
 rtl/key_event_decoder_pkg.sv | 19 +
 rtl/key_event_decoder_if.sv | 33 +++
 rtl/key_event_decoder.sv | 106 ++++++++++
 tb/tb_key_event_decoder.sv | 121 ++++++++++++
 4 files changed

// File: rtl/key_event_decoder_pkg.sv
// Shared definitions for the key event decoder: one-hot state encodings and
// default timing for a 50 MHz system clock.
package key_evt_pkg;

    typedef logic [4:0] state_t;

    localparam state_t IDLE   = 5'b00001;
    localparam state_t PRESS1 = 5'b00010;
    localparam state_t WAIT2  = 5'b00100;
    localparam state_t PRESS2 = 5'b01000;
    localparam state_t HOLD   = 5'b10000;

    // 1 s long press, 300 ms double-click window, 200 ms repeat period
    localparam int DEF_LONG_CYCLES   = 50_000_000;
    localparam int DEF_DCLICK_CYCLES = 15_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;
    localparam int DEF_CNT_W         = 26;

endpackage

// File: rtl/key_event_decoder_if.sv
// Debounced key inputs and classified event pulses exchanged between the key
// front end (master) and the event decoder (slave).
interface key_event_decoder_if;

    logic key_flag;
    logic key_state;
    logic click_pulse;
    logic dclick_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic busy;

    modport master (
        output key_flag,
        output key_state,
        input  click_pulse,
        input  dclick_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  busy
    );

    modport slave (
        input  key_flag,
        input  key_state,
        output click_pulse,
        output dclick_pulse,
        output long_pulse,
        output repeat_pulse,
        output busy
    );

endinterface

// File: rtl/key_event_decoder.sv
// Turns debounced key press/release activity into single-cycle click,
// double-click, long-press and auto-repeat pulses for the DDS controls.
module key_event_decoder
    import key_evt_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int DCLICK_CYCLES = DEF_DCLICK_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input logic                clk,
    input logic                rst,
    key_event_decoder_if.slave evt
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_cmp;
    logic             cnt_hit;
    logic             cnt_clr;
    logic             click_nxt;
    logic             dclick_nxt;
    logic             long_nxt;
    logic             repeat_nxt;

    // One shared counter; its terminal value depends on which timeout the state is waiting for.
    always_comb begin
        case (state)
            PRESS1:  cnt_cmp = CNT_W'(LONG_CYCLES - 1);
            WAIT2:   cnt_cmp = CNT_W'(DCLICK_CYCLES - 1);
            default: cnt_cmp = CNT_W'(REPEAT_CYCLES - 1);
        endcase
    end

    assign cnt_hit = (cnt == cnt_cmp);

    // Release beats the long timeout, and a second press beats the click timeout.
    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        click_nxt  = 1'b0;
        dclick_nxt = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (evt.key_flag) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (evt.key_state) begin
                    state_nxt = WAIT2;
                end else if (cnt_hit) begin
                    state_nxt = HOLD;
                    long_nxt  = 1'b1;
                end
            end
            WAIT2: begin
                if (evt.key_flag) begin
                    state_nxt  = PRESS2;
                    dclick_nxt = 1'b1;
                end else if (cnt_hit) begin
                    state_nxt = IDLE;
                    click_nxt = 1'b1;
                end
            end
            PRESS2: begin
                if (evt.key_state) state_nxt = IDLE;
            end
            HOLD: begin
                if (evt.key_state) begin
                    state_nxt = IDLE;
                end else if (cnt_hit) begin
                    repeat_nxt = 1'b1;
                    cnt_clr    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            evt.click_pulse  <= 1'b0;
            evt.dclick_pulse <= 1'b0;
            evt.long_pulse   <= 1'b0;
            evt.repeat_pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cnt_clr || (state_nxt != state)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            evt.click_pulse  <= click_nxt;
            evt.dclick_pulse <= dclick_nxt;
            evt.long_pulse   <= long_nxt;
            evt.repeat_pulse <= repeat_nxt;
        end
    end

    assign evt.busy = (state != IDLE);

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with shortened timing (long 20, dclick 10, repeat 5).
module tb_key_event_decoder;

    localparam int LONG   = 20;
    localparam int DCLICK = 10;
    localparam int REPEAT = 5;
    localparam int NCYC   = 55;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_event_decoder_if evt ();

    key_event_decoder #(
        .LONG_CYCLES   (LONG),
        .DCLICK_CYCLES (DCLICK),
        .REPEAT_CYCLES (REPEAT),
        .CNT_W         (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .evt (evt)
    );

    always #5 clk = ~clk;

    // Cycle numbers are relative to the last reset edge; 0 in an event field means "never".
    typedef struct {
        int flag1, rel1, flag2, rel2, spur1, spur2;
        int exp_click, exp_dclick, exp_long, exp_rep1, exp_rep2, busy_end;
    } vec_t;

    vec_t tbl [6];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [4:0] expected(input vec_t v, input int n);
        logic [4:0] e;
        e[4] = (n == v.exp_click);
        e[3] = (n == v.exp_dclick);
        e[2] = (n == v.exp_long);
        e[1] = (n == v.exp_rep1) || (n == v.exp_rep2);
        e[0] = (n > v.flag1) && (n < v.busy_end);
        return e;
    endfunction

    function automatic logic [4:0] outputs();
        return {evt.click_pulse, evt.dclick_pulse, evt.long_pulse, evt.repeat_pulse, evt.busy};
    endfunction

    task automatic apply_stimulus(input vec_t v, input int n);
        logic pressed;
        pressed = ((n >= v.flag1) && (n < v.rel1)) ||
                  ((v.flag2 != 0) && (n >= v.flag2) && (n < v.rel2));
        evt.key_state = ~pressed;
        evt.key_flag  = (n == v.flag1) || (n == v.flag2) || (n == v.spur1) || (n == v.spur2);
    endtask

    task automatic check_output(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b expected %b (click,dclick,long,repeat,busy)", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        evt.key_flag  = 1'b0;
        evt.key_state = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        for (int n = 1; n <= NCYC; n++) begin
            @(negedge clk);
            rst = 1'b0;
            check_output($sformatf("vec%0d cyc%0d", idx, n), outputs(), expected(v, n));
            apply_stimulus(v, n);
        end
    endtask

    initial begin
        evt.key_flag  = 1'b0;
        evt.key_state = 1'b1;

        //             flag1 rel1 flag2 rel2 spur1 spur2 click dclk long rep1 rep2 busy_end
        tbl[0] = '{10, 15,  0,  0,  0,  0, 26,  0,  0,  0,  0, 26};  // single click
        tbl[1] = '{10, 15, 20, 24,  0,  0,  0, 21,  0,  0,  0, 25};  // double click
        tbl[2] = '{10, 45,  0,  0,  0,  0,  0,  0, 31, 36, 41, 46};  // long + repeat
        tbl[3] = '{10, 30,  0,  0,  0,  0, 41,  0,  0,  0,  0, 41};  // release on long timeout
        tbl[4] = '{10, 15, 25, 28,  0,  0,  0, 26,  0,  0,  0, 29};  // second flag on click timeout
        tbl[5] = '{10, 45,  0,  0, 15, 33,  0,  0, 31, 36, 41, 46};  // spurious flags ignored

        for (int i = 0; i < 6; i++) begin
            do_reset();
            run_vector(tbl[i], i);
        end

        // Reset during HOLD: everything cleared the next cycle, then a clean single click.
        do_reset();
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            rst = 1'b0;
            check_output($sformatf("midrst cyc%0d", n), outputs(), expected(tbl[2], n));
            apply_stimulus(tbl[2], n);
        end
        rst = 1'b1;
        @(negedge clk);
        check_output("midrst cleared", outputs(), 5'b00000);
        rst           = 1'b0;
        evt.key_flag  = 1'b0;
        evt.key_state = 1'b1;
        run_vector(tbl[0], 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
